mac_acc_fp25: RTL and testbench
===============================

Name: mac_acc_fp25

Overview:
- Downstream stage of the fp(2,5) multiply-add pipeline.
- Consumes the registered 18-bit fixed-point result stream (a*b + c, already aligned and offset-corrected) and accumulates it into a wider signed sum over a frame.
- A frame ends on an explicit last flag or after a programmed sample count.
- The frame sum is presented on a valid/ready output port for the next layer (activation/requantise).

Parameters:
- IN_W, 18, input sample width, two's-complement signed.
- ACC_W, 26, accumulator and output width, signed; must be greater than IN_W.
- CNT_W, 9, width of the frame-length config and the sample counter.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  IN_W  signed product-sum sample from the multiply stage
- in_last  input  1  sample is the last of the frame
- cfg_len  input  CNT_W  frame length in samples; 0 = terminate on in_last only; sampled at first sample of each frame
- out_valid  output  1  out_data/out_cnt/out_sat hold a completed frame
- out_ready  input  1  consumer takes the frame
- out_data  output  ACC_W  signed saturated frame sum
- out_cnt  output  CNT_W  number of samples accumulated in the frame
- out_sat  output  1  saturation occurred at any point in the frame (sticky per frame)

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_cnt=0, out_sat=0.
  - Internal acc=0, cnt=0, sat=0, len_q=0; state IDLE.
  - Takes priority over every other event, including mid-frame; a partial frame is discarded.
- in_ready = !out_valid || out_ready. The combinational path from out_ready is allowed. No input is accepted while a completed frame is stalled.
- Accept = in_valid && in_ready.
- States:
  - IDLE: no frame open.
  - ACC: frame open, at least one sample taken.
  - Completion is a transition back to IDLE with out_valid set.
- Per accepted sample:
  - Sign-extend in_data to ACC_W+1 bits. Compute s = acc_base + in_data, where acc_base = 0 in IDLE and acc in ACC.
  - If s > 2^(ACC_W-1)-1, clamp to max and set sat. If s < -2^(ACC_W-1), clamp to min and set sat.
  - cnt_next = (IDLE ? 1 : cnt+1).
  - In IDLE, latch len_q = cfg_len.
- Frame end: on an accepted sample with in_last=1, or with len_q!=0 && cnt_next==len_q (using the freshly latched value in IDLE). On frame end:
  - The next cycle: out_valid=1, out_data=clamped s, out_cnt=cnt_next, out_sat=sat|this-sample-saturated.
  - acc, cnt and sat are cleared; state goes to IDLE.
- Otherwise acc=s, cnt=cnt_next, state ACC.
- Latency: 1 cycle from final-sample accept to out_valid.
- Output holds stable while out_valid && !out_ready. out_valid drops the cycle after the handshake, unless a new frame completes on that same edge, in which case it stays 1 with new data.
- Simultaneous output handshake and input accept is legal. The new sample starts the next frame with no bubble. A single-sample frame (in_last on first sample, or cfg_len=1) can complete back-to-back every cycle.
- cnt saturates at 2^CNT_W-1 if in_last never arrives with cfg_len=0. The frame then continues; out_cnt reports the capped value.
- in_data is ignored when !in_valid. cfg_len changes mid-frame have no effect.

Test Plan:
- cfg_len=4, four samples +1000, no backpressure -> one cycle after 4th accept: out_valid=1, out_data=4000, out_cnt=4, out_sat=0.
- cfg_len=0, samples +5, -12, +3 with in_last on the third -> out_data=-4, out_cnt=3.
- Frame completes with out_ready=0 for 5 cycles -> in_ready=0, out_data stable for 5 cycles. Raising out_ready with in_valid=1 accepts the next sample that same cycle.
- cfg_len=300, 300 samples of +131071 -> out_data=33554431, out_sat=1, out_cnt=300. Next frame (+1, in_last) -> out_data=1, out_sat=0.
- cfg_len=300, 300 samples of -131072 -> out_data=-33554432, out_sat=1.
- Reset asserted after 2 of 4 samples, then 4 fresh samples of +7 with cfg_len=4 -> out_data=28, out_cnt=4. No output is produced for the aborted frame.

Source files
------------

// File: rtl/mac_acc_fp25_if.sv
// Sample-in / frame-sum-out port bundle for the fp(2,5) accumulator stage.
//
// Both ports use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both 1. The sender holds its payload stable while valid
// is 1 and ready is 0. Ready may depend combinationally on the other side.
interface mac_acc_fp25_if #(
    parameter int IN_W  = 18,
    parameter int ACC_W = 26,
    parameter int CNT_W = 9
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_last;
    logic [CNT_W-1:0]        cfg_len;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic [CNT_W-1:0]        out_cnt;
    logic                    out_sat;

    modport master (
        output in_valid, in_data, in_last, cfg_len, out_ready,
        input  in_ready, out_valid, out_data, out_cnt, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, cfg_len, out_ready,
        output in_ready, out_valid, out_data, out_cnt, out_sat
    );
endinterface

// File: rtl/mac_acc_fp25.sv
// Frame accumulator: sums signed product-sum samples into a saturating
// ACC_W-bit total; a frame closes on in_last or after cfg_len samples and the
// sum is presented one cycle later on the valid/ready output port.
module mac_acc_fp25 #(
    parameter int IN_W  = 18,
    parameter int ACC_W = 26,
    parameter int CNT_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    mac_acc_fp25_if.slave     bus,
    output logic              dbg_state
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_MAX = '1;
    localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        len_q;
    logic                    sat_q;

    logic                    out_valid_q;
    logic signed [ACC_W-1:0] out_data_q;
    logic [CNT_W-1:0]        out_cnt_q;
    logic                    out_sat_q;

    logic                    in_ready_c;
    logic                    accept;
    logic                    idle;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W:0]   sum_wide;
    logic                    ovf_pos, ovf_neg;
    logic signed [ACC_W-1:0] sum_clamped;
    logic                    sat_now;
    logic                    sat_run;
    logic [CNT_W-1:0]        cnt_next;
    logic [CNT_W-1:0]        len_eff;
    logic                    frame_end;

    assign idle   = (state_q == S_IDLE);
    assign accept = bus.in_valid && in_ready_c;

    // Datapath: one extra guard bit makes the add exact, then clamp to ACC_W.
    always_comb begin
        acc_base    = idle ? '0 : acc_q;
        sum_wide    = {acc_base[ACC_W-1], acc_base}
                    + {{(ACC_W+1-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
        ovf_pos     = !sum_wide[ACC_W] &&  sum_wide[ACC_W-1];
        ovf_neg     =  sum_wide[ACC_W] && !sum_wide[ACC_W-1];
        sat_now     = ovf_pos || ovf_neg;
        sum_clamped = ovf_pos ? ACC_MAX :
                      ovf_neg ? ACC_MIN : sum_wide[ACC_W-1:0];
        sat_run     = (idle ? 1'b0 : sat_q) || sat_now;
        // Counter sticks at all-ones so runaway frames report the cap.
        cnt_next    = idle ? CNT_ONE :
                      (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        // The first sample of a frame compares against the live cfg_len,
        // which is the value being latched into len_q on that edge.
        len_eff     = idle ? bus.cfg_len : len_q;
        frame_end   = bus.in_last || ((len_eff != '0) && (cnt_next == len_eff));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: an accepted sample either closes the frame or keeps it open.
    always_comb begin
        state_d = state_q;
        if (accept) state_d = frame_end ? S_IDLE : S_ACC;
    end

    // Outputs: input is blocked only while a finished frame is stalled.
    always_comb begin
        in_ready_c = !out_valid_q || bus.out_ready;
        dbg_state  = state_q;
    end

    // Accumulator, counter, sticky saturation and the output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            if (accept) begin
                if (idle) len_q <= bus.cfg_len;
                if (frame_end) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= sum_clamped;
                    out_cnt_q   <= cnt_next;
                    out_sat_q   <= sat_run;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    sat_q       <= 1'b0;
                end else begin
                    acc_q <= sum_clamped;
                    cnt_q <= cnt_next;
                    sat_q <= sat_run;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_mac_acc_fp25.sv
// Bench for mac_acc_fp25: directed frames from the test plan plus randomized
// frames with random backpressure, scored against a frame-level model.
module tb_mac_acc_fp25;
    localparam int IN_W  = 18;
    localparam int ACC_W = 26;
    localparam int CNT_W = 9;
    localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (ACC_W-1));
    localparam int CNT_CAP = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic dbg_state;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_bp  = 0;

    mac_acc_fp25_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mac_acc_fp25 #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model / scoreboard ----------------
    logic [ACC_W-1:0] exp_data_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];
    logic             exp_sat_q[$];
    longint m_acc;
    int     m_cnt, m_len, m_frames;
    bit     m_sat, m_open;
    int     frames_seen = 0;
    logic signed [ACC_W-1:0] last_data;
    logic [CNT_W-1:0]        last_cnt;
    logic                    last_sat;

    function automatic void model_reset();
        m_open = 0;
        exp_data_q.delete();
        exp_cnt_q.delete();
        exp_sat_q.delete();
    endfunction

    // Frame semantics in plain integer arithmetic: running saturating sum,
    // sticky flag, capped count, end on last flag or programmed length.
    function automatic void model_sample(int d, bit last, int len_now);
        if (!m_open) begin
            m_open = 1; m_acc = 0; m_cnt = 0; m_sat = 0; m_len = len_now;
        end
        m_acc = m_acc + d;
        if (m_acc > MAXV) begin m_acc = MAXV; m_sat = 1; end
        if (m_acc < MINV) begin m_acc = MINV; m_sat = 1; end
        m_cnt = (m_cnt < CNT_CAP) ? m_cnt + 1 : CNT_CAP;
        if (last || (m_len != 0 && m_cnt == m_len)) begin
            exp_data_q.push_back(ACC_W'(m_acc));
            exp_cnt_q.push_back(CNT_W'(m_cnt));
            exp_sat_q.push_back(m_sat);
            m_frames++;
            m_open = 0;
        end
    endfunction

    // Output monitor: every output handshake is checked against the model.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            frames_seen++;
            last_data = bus.out_data;
            last_cnt  = bus.out_cnt;
            last_sat  = bus.out_sat;
            n_checks++;
            if (exp_data_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_frame: got data=%0d cnt=%0d, expected no frame",
                         bus.out_data, bus.out_cnt);
            end else begin
                logic [ACC_W-1:0] ed;
                logic [CNT_W-1:0] ec;
                logic             es;
                ed = exp_data_q.pop_front();
                ec = exp_cnt_q.pop_front();
                es = exp_sat_q.pop_front();
                if ({bus.out_data, bus.out_cnt, bus.out_sat} !== {ed, ec, es}) begin
                    n_fail++;
                    $display("FAIL frame_out: got data=%0d cnt=%0d sat=%0b, expected data=%0d cnt=%0d sat=%0b",
                             bus.out_data, bus.out_cnt, bus.out_sat,
                             $signed(ed), ec, es);
                end
            end
        end
    end

    // Random backpressure when enabled.
    always begin
        @(posedge clk);
        #1;
        if (rand_bp) bus.out_ready = ($urandom_range(0, 2) != 0);
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int d, input bit last, output int waits);
        bit done;
        waits = 0;
        done  = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = IN_W'(d);
        bus.in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                model_sample(d, last, int'(bus.cfg_len));
                done = 1;
            end else if (waits >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stayed %b for %0d cycles, expected 1",
                         bus.in_ready, waits);
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_data_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (exp_data_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d frames outstanding, expected 0", exp_data_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_cnt, bus.out_sat, dbg_state, bus.in_ready}
            !== {1'b0, {ACC_W{1'b0}}, {CNT_W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b d=%0d c=%0d s=%b st=%b rdy=%b, expected 0 0 0 0 0 1",
                     bus.out_valid, bus.out_data, bus.out_cnt, bus.out_sat, dbg_state, bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_len4();
        int w;
        bus.cfg_len = 9'd4;
        send(1000, 0, w);
        n_checks++;
        if (dbg_state !== 1'b1) begin
            n_fail++;
            $display("FAIL state_acc: got %b, expected 1", dbg_state);
        end
        repeat (3) send(1000, 0, w);
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_cnt, bus.out_sat}
            !== {1'b1, ACC_W'(4000), CNT_W'(4), 1'b0}) begin
            n_fail++;
            $display("FAIL len4_frame: got v=%b d=%0d c=%0d s=%b, expected 1 4000 4 0",
                     bus.out_valid, bus.out_data, bus.out_cnt, bus.out_sat);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_last_flag();
        int w;
        bus.cfg_len = 9'd0;
        send(5, 0, w);
        send(-12, 0, w);
        send(3, 1, w);
        drain();
        n_checks++;
        if ({last_data, last_cnt} !== {ACC_W'(-4), CNT_W'(3)}) begin
            n_fail++;
            $display("FAIL last_flag: got d=%0d c=%0d, expected -4 3", last_data, last_cnt);
        end
    endtask

    task automatic test_stall();
        int w;
        bus.cfg_len   = 9'd0;
        bus.out_ready = 1'b0;
        send(10, 0, w);
        send(20, 1, w);
        bus.in_valid = 1'b1;
        bus.in_data  = IN_W'(5);
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_data} !== {1'b1, 1'b0, ACC_W'(30)}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b rdy=%b d=%0d, expected 1 0 30",
                         i, bus.out_valid, bus.in_ready, bus.out_data);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(5, 1, w);
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL stall_release: waited %0d cycles, expected 0", w);
        end
        drain();
    endtask

    task automatic test_saturation();
        int w;
        bus.cfg_len = 9'd300;
        for (int i = 0; i < 300; i++) send(131071, 0, w);
        drain();
        n_checks++;
        if ({last_data, last_cnt, last_sat} !== {ACC_W'(33554431), CNT_W'(300), 1'b1}) begin
            n_fail++;
            $display("FAIL sat_pos: got d=%0d c=%0d s=%b, expected 33554431 300 1",
                     last_data, last_cnt, last_sat);
        end
        send(1, 1, w);
        drain();
        n_checks++;
        if ({last_data, last_sat} !== {ACC_W'(1), 1'b0}) begin
            n_fail++;
            $display("FAIL sat_cleared: got d=%0d s=%b, expected 1 0", last_data, last_sat);
        end
        for (int i = 0; i < 300; i++) send(-131072, 0, w);
        drain();
        n_checks++;
        if ({last_data, last_sat} !== {ACC_W'(-33554432), 1'b1}) begin
            n_fail++;
            $display("FAIL sat_neg: got d=%0d s=%b, expected -33554432 1", last_data, last_sat);
        end
    endtask

    task automatic test_cnt_cap();
        int w;
        bus.cfg_len = 9'd0;
        for (int i = 0; i < 515; i++) send(1, 0, w);
        send(1, 1, w);
        drain();
        n_checks++;
        if ({last_data, last_cnt} !== {ACC_W'(516), CNT_W'(511)}) begin
            n_fail++;
            $display("FAIL cnt_cap: got d=%0d c=%0d, expected 516 511", last_data, last_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int w, seen0;
        bus.cfg_len = 9'd1;
        seen0 = frames_seen;
        for (int i = 0; i < 10; i++) begin
            send(int'($urandom_range(0, 262143)) - 131072, 0, w);
            n_checks++;
            if (w != 0) begin
                n_fail++;
                $display("FAIL b2b_bubble[%0d]: waited %0d cycles, expected 0", i, w);
            end
        end
        drain();
        n_checks++;
        if (frames_seen - seen0 != 10) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d frames, expected 10", frames_seen - seen0);
        end
    endtask

    task automatic test_mid_reset();
        int w, seen0;
        bus.cfg_len = 9'd4;
        seen0 = frames_seen;
        send(7, 0, w);
        send(7, 0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, dbg_state} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_state: got v=%b st=%b, expected 0 0", bus.out_valid, dbg_state);
        end
        @(posedge clk);
        #1;
        repeat (4) send(7, 0, w);
        drain();
        n_checks++;
        if ({last_data, last_cnt, frames_seen - seen0} !== {ACC_W'(28), CNT_W'(4), 32'd1}) begin
            n_fail++;
            $display("FAIL mid_reset_frame: got d=%0d c=%0d frames=%0d, expected 28 4 1",
                     last_data, last_cnt, frames_seen - seen0);
        end
    endtask

    task automatic test_random();
        int w;
        int lens[5] = '{0, 1, 3, 5, 17};
        rand_bp = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) bus.cfg_len = CNT_W'(lens[$urandom_range(0, 4)]);
            send(int'($urandom_range(0, 262143)) - 131072, ($urandom_range(0, 7) == 0), w);
        end
        bus.cfg_len = 9'd0;
        send(0, 1, w);
        rand_bp = 0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.cfg_len   = '0;
        bus.out_ready = 1'b1;
        m_frames      = 0;
        m_open        = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_len4();
        test_last_flag();
        test_stall();
        test_saturation();
        test_cnt_cap();
        test_back_to_back();
        test_mid_reset();
        test_random();
        n_checks++;
        if (exp_data_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_frames: got %0d outstanding, expected 0", exp_data_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
